imm_gen_stage: RTL and testbench

- Registered, parametrised immediate-generation pipeline stage between fetch and decode/execute.
- Decodes the immediate and its format from a 32-bit RV32I/RV64I instruction.
- Sign- or zero-extends the immediate to XLEN and flags illegal encodings.
- Passes results downstream through a valid/ready handshake, with an optional 2-entry skid buffer so back-pressure never drops or reorders instructions.

---
 rtl/imm_gen_stage.sv | 234 +++++++++++++++++++++++
 tb/tb_imm_gen_stage.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered RV32I/RV64I immediate-generation stage.
// Decodes the immediate and its format from the incoming instruction,
// flags illegal encodings, and hands results downstream over valid/ready.
// With SKID=1 a 2-entry skid buffer keeps in_ready registered; with SKID=0
// a single output register is used.
module imm_gen_stage #(
  parameter int XLEN         = 32,
  parameter bit SKID         = 1'b1,
  parameter bit ENABLE_ZICSR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  // One buffered entry: instruction, immediate, format, illegal flag.
  localparam int EW = 32 + XLEN + 3 + 1;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_Z = 3'd6;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            shift_op;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] imm_sh5, imm_sh6, imm_z;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;
  logic [EW-1:0]   dec_entry;
  logic [EW-1:0]   main_q, main_d;
  logic            in_xfer, out_xfer;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  // funct3 001 (SLLI) and 101 (SRLI/SRAI) carry a shift amount, not an immediate
  assign shift_op = (funct3[1:0] == 2'b01);

  // Candidate immediates; signed casts sign-extend straight to XLEN
  assign imm_i   = XLEN'($signed(in_instr[31:20]));
  assign imm_s   = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b   = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                  in_instr[11:8], 1'b0}));
  assign imm_u   = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j   = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                  in_instr[30:21], 1'b0}));
  assign imm_sh5 = XLEN'(in_instr[24:20]);
  assign imm_sh6 = XLEN'(in_instr[25:20]);
  assign imm_z   = XLEN'(in_instr[19:15]);

  // Select format and immediate from the opcode; unknown encodings are illegal
  always_comb begin
    dec_imm     = '0;
    dec_fmt     = FMT_R;
    dec_illegal = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end else begin
      case (opcode)
        7'b0010011: begin
          dec_fmt = FMT_I;
          if (shift_op) dec_imm = (XLEN == 64) ? imm_sh6 : imm_sh5;
          else          dec_imm = imm_i;
        end
        7'b0000011, 7'b1100111, 7'b0001111: begin
          dec_fmt = FMT_I;
          dec_imm = imm_i;
        end
        7'b0100011: begin
          dec_fmt = FMT_S;
          dec_imm = imm_s;
        end
        7'b1100011: begin
          dec_fmt = FMT_B;
          dec_imm = imm_b;
        end
        7'b1101111: begin
          dec_fmt = FMT_J;
          dec_imm = imm_j;
        end
        7'b0110111, 7'b0010111: begin
          dec_fmt = FMT_U;
          dec_imm = imm_u;
        end
        7'b0110011: begin
          dec_fmt = FMT_R;
        end
        7'b1110011: begin
          if (funct3[2] && ENABLE_ZICSR) begin
            dec_fmt = FMT_Z;
            dec_imm = imm_z;
          end else begin
            dec_fmt = FMT_I;
            dec_imm = imm_i;
          end
        end
        7'b0011011: begin
          // OP-IMM-32 word shifts only ever use a 5-bit shamt
          if (XLEN == 64) begin
            dec_fmt = FMT_I;
            dec_imm = shift_op ? imm_sh5 : imm_i;
          end else begin
            dec_illegal = 1'b1;
          end
        end
        7'b0111011: begin
          if (XLEN != 64) dec_illegal = 1'b1;
        end
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  assign dec_entry = {in_instr, dec_imm, dec_fmt, dec_illegal};
  assign {out_instr, out_imm, out_fmt, out_illegal} = main_q;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  generate
    if (SKID) begin : g_skid
      state_t        state_q, state_d;
      logic [EW-1:0] skid_q, skid_d;
      logic          in_ready_q, in_ready_d;

      // Buffer occupancy and entry movement; flush empties the buffer
      always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        skid_d     = skid_q;
        if (flush) begin
          state_d = ST_EMPTY;
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (in_xfer) begin
                state_d = ST_ONE;
                main_d  = dec_entry;
              end
            end
            ST_ONE: begin
              if (in_xfer && !out_xfer) begin
                state_d = ST_TWO;
                skid_d  = dec_entry;
              end else if (!in_xfer && out_xfer) begin
                state_d = ST_EMPTY;
              end else if (in_xfer && out_xfer) begin
                main_d = dec_entry;
              end
            end
            ST_TWO: begin
              if (out_xfer) begin
                state_d = ST_ONE;
                main_d  = skid_q;
              end
            end
            default: state_d = ST_EMPTY;
          endcase
        end
        in_ready_d = (state_d != ST_TWO);
      end

      // State, entry and registered-ready flops
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q    <= ST_EMPTY;
          main_q     <= '0;
          skid_q     <= '0;
          in_ready_q <= 1'b1;
        end else begin
          state_q    <= state_d;
          main_q     <= main_d;
          skid_q     <= skid_d;
          in_ready_q <= in_ready_d;
        end
      end

      // The ready flop already holds 1 during reset; gating keeps it low until release
      assign in_ready  = in_ready_q && !rst;
      assign out_valid = (state_q != ST_EMPTY);
    end else begin : g_single
      logic valid_q, valid_d;

      // Single register: load on accept, drain on output, drop on flush
      always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (flush) begin
          valid_d = 1'b0;
        end else if (in_xfer) begin
          valid_d = 1'b1;
          main_d  = dec_entry;
        end else if (out_xfer) begin
          valid_d = 1'b0;
        end
      end

      // Valid and entry flops
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          main_q  <= '0;
        end else begin
          valid_q <= valid_d;
          main_q  <= main_d;
        end
      end

      assign in_ready  = (!valid_q || out_ready) && !rst;
      assign out_valid = valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_imm_gen_stage.sv
// Testbench for imm_gen_stage: an RV32 skid-buffer instance and an RV64
// single-register instance without Zicsr share stimulus. A per-instance
// scoreboard queue is filled on acceptance and drained on output transfers;
// directed checks cover reset, handshake timing, flush and mid-stream reset.
module tb_imm_gen_stage;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] w;
    logic [31:0] imm32;
    logic [2:0]  f32;
    logic        i32;
    logic [63:0] imm64;
    logic [2:0]  f64;
    logic        i64;
  } vec_t;

  logic        clk, rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_instr, out_imm;
  logic [2:0]  out_fmt;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [31:0] out_instr64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_pop32 = 0;
  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;
  vec_t vq[$];

  localparam logic [31:0] A = 32'hFFF00093;
  localparam logic [31:0] B = 32'h123450B7;
  localparam logic [31:0] C = 32'hFE000EE3;
  localparam logic [31:0] D = 32'h0010006F;

  imm_gen_stage #(.XLEN(32), .SKID(1'b1), .ENABLE_ZICSR(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_illegal(out_illegal)
  );

  imm_gen_stage #(.XLEN(64), .SKID(1'b0), .ENABLE_ZICSR(1'b0)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_instr(out_instr64), .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_illegal(out_illegal64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference decoder, indexed by the 5-bit major opcode field w[6:2]
  function automatic exp_t ref_dec(input logic [31:0] w, input bit rv64, input bit zicsr);
    exp_t r;
    logic [63:0] i_imm, s_imm, b_imm, u_imm, j_imm, sh5, sh6, zimm;
    i_imm = {{52{w[31]}}, w[31:20]};
    s_imm = {{52{w[31]}}, w[31:25], w[11:7]};
    b_imm = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    u_imm = {{32{w[31]}}, w[31:12], 12'h000};
    j_imm = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    sh5   = {59'd0, w[24:20]};
    sh6   = {58'd0, w[25:20]};
    zimm  = {59'd0, w[19:15]};
    r.instr = w; r.imm = 64'd0; r.fmt = 3'd0; r.ill = 1'b0;
    if (w[1:0] != 2'b11) r.ill = 1'b1;
    else begin
      case (w[6:2])
        5'b00100: begin r.fmt = 3'd1; r.imm = (w[13:12] == 2'b01) ? (rv64 ? sh6 : sh5) : i_imm; end
        5'b00000, 5'b11001, 5'b00011: begin r.fmt = 3'd1; r.imm = i_imm; end
        5'b01000: begin r.fmt = 3'd2; r.imm = s_imm; end
        5'b11000: begin r.fmt = 3'd3; r.imm = b_imm; end
        5'b11011: begin r.fmt = 3'd5; r.imm = j_imm; end
        5'b01101, 5'b00101: begin r.fmt = 3'd4; r.imm = u_imm; end
        5'b01100: r.fmt = 3'd0;
        5'b11100: begin
          if (w[14] && zicsr) begin r.fmt = 3'd6; r.imm = zimm; end
          else begin r.fmt = 3'd1; r.imm = i_imm; end
        end
        5'b00110: begin
          if (rv64) begin r.fmt = 3'd1; r.imm = (w[13:12] == 2'b01) ? sh5 : i_imm; end
          else r.ill = 1'b1;
        end
        5'b01110: if (!rv64) r.ill = 1'b1;
        default: r.ill = 1'b1;
      endcase
    end
    return r;
  endfunction

  // Scoreboard for the RV32 skid instance
  always @(negedge clk) begin
    if (rst || flush) q32.delete();
    else begin
      if (out_valid && out_ready) begin
        chk1("sb32_avail", q32.size() != 0, 1'b1);
        if (q32.size() != 0) begin
          e32 = q32.pop_front();
          n_pop32++;
          chkw("sb32_instr", 64'(out_instr), 64'(e32.instr));
          chkw("sb32_imm", 64'(out_imm), 64'(e32.imm[31:0]));
          chkw("sb32_fmt", 64'(out_fmt), 64'(e32.fmt));
          chk1("sb32_ill", out_illegal, e32.ill);
        end
      end
      if (in_valid && in_ready) q32.push_back(ref_dec(in_instr, 1'b0, 1'b1));
    end
  end

  // Scoreboard for the RV64 single-register instance
  always @(negedge clk) begin
    if (rst || flush) q64.delete();
    else begin
      if (out_valid64 && out_ready) begin
        chk1("sb64_avail", q64.size() != 0, 1'b1);
        if (q64.size() != 0) begin
          e64 = q64.pop_front();
          chkw("sb64_instr", 64'(out_instr64), 64'(e64.instr));
          chkw("sb64_imm", out_imm64, e64.imm);
          chkw("sb64_fmt", 64'(out_fmt64), 64'(e64.fmt));
          chk1("sb64_ill", out_illegal64, e64.ill);
        end
      end
      if (in_valid && in_ready64) q64.push_back(ref_dec(in_instr, 1'b1, 1'b0));
    end
  end

  task automatic chk_reset(input string tag);
    chk1({tag, "_in_ready"}, in_ready, 1'b0);
    chk1({tag, "_out_valid"}, out_valid, 1'b0);
    chkw({tag, "_out_instr"}, 64'(out_instr), 64'd0);
    chkw({tag, "_out_imm"}, 64'(out_imm), 64'd0);
    chkw({tag, "_out_fmt"}, 64'(out_fmt), 64'd0);
    chk1({tag, "_out_ill"}, out_illegal, 1'b0);
    chk1({tag, "_in_ready64"}, in_ready64, 1'b0);
    chk1({tag, "_out_valid64"}, out_valid64, 1'b0);
    chkw({tag, "_out_imm64"}, out_imm64, 64'd0);
  endtask

  task automatic add_vec(input logic [31:0] w, input logic [31:0] i32v, input logic [2:0] f32,
                         input logic l32, input logic [63:0] i64v, input logic [2:0] f64,
                         input logic l64);
    vec_t v;
    v.w = w; v.imm32 = i32v; v.f32 = f32; v.i32 = l32;
    v.imm64 = i64v; v.f64 = f64; v.i64 = l64;
    vq.push_back(v);
  endtask

  // Watchdog: the directed sequence is a few hundred cycles
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b1;

    add_vec(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    add_vec(32'h4030D093, 32'h00000003, 3'd1, 1'b0, 64'h3, 3'd1, 1'b0);
    add_vec(32'h4230D093, 32'h00000003, 3'd1, 1'b0, 64'h23, 3'd1, 1'b0);
    add_vec(32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);
    add_vec(32'h123450B7, 32'h12345000, 3'd4, 1'b0, 64'h12345000, 3'd4, 1'b0);
    add_vec(32'h80000017, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
    add_vec(32'h3002D073, 32'h00000005, 3'd6, 1'b0, 64'h300, 3'd1, 1'b0);
    add_vec(32'h00000000, 32'h00000000, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1);
    add_vec(32'h0010009B, 32'h00000000, 3'd0, 1'b1, 64'h1, 3'd1, 1'b0);
    add_vec(32'hFE112C23, 32'hFFFFFFF8, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0);
    add_vec(32'h0010006F, 32'h00000800, 3'd5, 1'b0, 64'h800, 3'd5, 1'b0);
    add_vec(32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0);
    add_vec(32'h002081B3, 32'h00000000, 3'd0, 1'b0, 64'h0, 3'd0, 1'b0);
    add_vec(32'h002081BB, 32'h00000000, 3'd0, 1'b1, 64'h0, 3'd0, 1'b0);
    add_vec(32'h80009073, 32'hFFFFF800, 3'd1, 1'b0, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b0);
    add_vec(32'h0210909B, 32'h00000000, 3'd0, 1'b1, 64'h1, 3'd1, 1'b0);
    add_vec(32'h0FF0000F, 32'h000000FF, 3'd1, 1'b0, 64'hFF, 3'd1, 1'b0);
    add_vec(32'h00000001, 32'h00000000, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1);
    add_vec(32'h0000007F, 32'h00000000, 3'd0, 1'b1, 64'h0, 3'd0, 1'b1);
    add_vec(32'h00102073, 32'h00000001, 3'd1, 1'b0, 64'h1, 3'd1, 1'b0);

    // Reset values, then ready on the first cycle after release
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk1("release_in_ready", in_ready, 1'b1);
    chk1("release_in_ready64", in_ready64, 1'b1);
    chk1("release_out_valid", out_valid, 1'b0);

    // Directed decode vectors, one at a time with out_ready=1
    foreach (vq[i]) begin
      @(posedge clk); #1 in_valid = 1'b1; in_instr = vq[i].w;
      @(negedge clk);
      chk1($sformatf("dec%0d_in_ready", i), in_ready, 1'b1);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      $display("decode %0d instr=%08h imm32=%08h fmt32=%0d ill32=%b imm64=%016h fmt64=%0d ill64=%b",
               i, vq[i].w, out_imm, out_fmt, out_illegal, out_imm64, out_fmt64, out_illegal64);
      chk1($sformatf("dec%0d_valid", i), out_valid, 1'b1);
      chkw($sformatf("dec%0d_imm32", i), 64'(out_imm), 64'(vq[i].imm32));
      chkw($sformatf("dec%0d_fmt32", i), 64'(out_fmt), 64'(vq[i].f32));
      chk1($sformatf("dec%0d_ill32", i), out_illegal, vq[i].i32);
      chk1($sformatf("dec%0d_valid64", i), out_valid64, 1'b1);
      chkw($sformatf("dec%0d_imm64", i), out_imm64, vq[i].imm64);
      chkw($sformatf("dec%0d_fmt64", i), 64'(out_fmt64), 64'(vq[i].f64));
      chk1($sformatf("dec%0d_ill64", i), out_illegal64, vq[i].i64);
    end

    // Skid buffer: A,B accepted under back-pressure, C held, then drained in order
    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1; in_instr = A;
    @(negedge clk);
    chk1("skid_a_ready", in_ready, 1'b1);
    @(posedge clk); #1 in_instr = B;
    @(negedge clk);
    chk1("skid_b_ready", in_ready, 1'b1);
    chk1("skid_a_valid", out_valid, 1'b1);
    chkw("skid_a_instr", 64'(out_instr), 64'(A));
    @(posedge clk); #1 in_instr = C;
    @(negedge clk);
    chk1("skid_c_blocked", in_ready, 1'b0);
    chkw("skid_a_stable", 64'(out_instr), 64'(A));
    @(posedge clk); #1;
    @(negedge clk);
    chk1("skid_c_still_blocked", in_ready, 1'b0);
    chkw("skid_a_imm_stable", 64'(out_imm), 64'hFFFFFFFF);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    $display("stream out instr=%08h valid=%b", out_instr, out_valid);
    chk1("skid_out_a_valid", out_valid, 1'b1);
    chkw("skid_out_a", 64'(out_instr), 64'(A));
    @(posedge clk); #1;
    @(negedge clk);
    $display("stream out instr=%08h valid=%b", out_instr, out_valid);
    chk1("skid_out_b_valid", out_valid, 1'b1);
    chkw("skid_out_b", 64'(out_instr), 64'(B));
    chk1("skid_ready_after_drain", in_ready, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    $display("stream out instr=%08h valid=%b", out_instr, out_valid);
    chk1("skid_out_c_valid", out_valid, 1'b1);
    chkw("skid_out_c", 64'(out_instr), 64'(C));
    chkw("skid_out_c_imm", 64'(out_imm), 64'hFFFFFFFC);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("skid_empty", out_valid, 1'b0);

    // Flush while both entries are full, with an input presented
    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1; in_instr = A;
    @(posedge clk); #1 in_instr = B;
    @(posedge clk); #1 in_instr = C; flush = 1'b1;
    @(negedge clk);
    chk1("flush_two_in_ready", in_ready, 1'b0);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk1("flush_two_valid", out_valid, 1'b0);
    chk1("flush_two_ready", in_ready, 1'b1);
    chk1("flush_two_valid64", out_valid64, 1'b0);

    // Flush while empty: the input offered with in_ready=1 is dropped
    @(posedge clk); #1 in_valid = 1'b1; in_instr = C; flush = 1'b1;
    @(negedge clk);
    chk1("flush_empty_ready", in_ready, 1'b1);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk1("flush_drop_valid", out_valid, 1'b0);
    chk1("flush_drop_valid64", out_valid64, 1'b0);

    // The next input emerges alone
    @(posedge clk); #1 out_ready = 1'b1; in_valid = 1'b1; in_instr = D;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    $display("post-flush out instr=%08h imm=%08h fmt=%0d", out_instr, out_imm, out_fmt);
    chk1("post_flush_valid", out_valid, 1'b1);
    chkw("post_flush_instr", 64'(out_instr), 64'(D));
    chkw("post_flush_imm", 64'(out_imm), 64'h800);
    chkw("post_flush_fmt", 64'(out_fmt), 64'd5);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("post_flush_alone", out_valid, 1'b0);

    // Reset in the middle of a stalled stream
    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1; in_instr = A;
    @(posedge clk); #1 in_instr = B;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk1("midrst_ready_low", in_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset("midrst");
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk1("midrst_release_ready", in_ready, 1'b1);
    chk1("midrst_release_valid", out_valid, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chkw("sb32_drained", 64'(q32.size()), 64'd0);
    chkw("sb64_drained", 64'(q64.size()), 64'd0);
    chkw("sb32_pop_count", 64'(n_pop32), 64'd24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
